onehot_scan_encoder: RTL and testbench
======================================

Name: onehot_scan_encoder

Overview:
- Sequential 64-to-6 encoder; the inverse of the 6:64 decoder.
- Accepts a 64-bit request vector over a valid/ready handshake.
- Emits the 6-bit index of every set bit in ascending order, one index per accepted output beat.
- Sits between request-vector producers (interrupt/bank-select masks) and index-consuming logic.

Parameters:
N, 64, width of input vector (power of two)
W, 6, index width = log2(N)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  producer has a vector
in_ready  out  1  block can accept a vector
in_vec  in  N  request vector, bit i = index i requested
out_valid  out  1  out_idx/out_last/out_none/out_beat are valid
out_ready  in  1  consumer accepts current beat
out_idx  out  W  index of the lowest still-pending set bit
out_last  out  1  current beat is the final beat for this vector
out_none  out  1  accepted vector was all zeros
out_beat  out  W  beat number within the current vector, starting at 0

Behaviour:
- Reset is asynchronous on reset_n low; release is synchronous to clk.
- Reset values: state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, out_none=0, out_beat=0, in_ready=1.
- Reset asserted mid-vector abandons all pending bits; no further beats are emitted for that vector.
- States: IDLE, EMIT.
- in_ready = (state==IDLE). No input overlap with emission; in_ready is high only in IDLE.
- IDLE, in_valid=1 (accept), on the clock edge:
  - pending <= in_vec, out_beat <= 0.
  - zero_flag <= (in_vec==0).
  - state <= EMIT.
- Accept latency: vector accepted at edge T; out_valid=1 in the cycle after T.
- EMIT outputs, all derived only from registered state (no in_* to out_* combinational path):
  - out_valid=1.
  - out_idx = position of the lowest set bit of pending; 0 when pending==0.
  - out_last = 1 when pending has at most one set bit.
  - out_none = zero_flag.
- EMIT, out_ready=1 (beat accepted):
  - Clear the lowest set bit of pending.
  - out_beat <= out_beat+1.
  - If out_last: state <= IDLE, out_valid drops next cycle, in_ready rises next cycle.
- EMIT, out_ready=0: all out_* held stable; pending unchanged.
- Zero vector: exactly one beat with out_idx=0, out_none=1, out_last=1, out_beat=0.
- Nonzero vector with k set bits: exactly k beats; out_none=0 on every beat; out_last=1 only on beat k-1.
- out_beat counts 0..k-1. Maximum is 63 (all ones), so it never wraps within a vector.
- Throughput with out_ready held 1: k beats plus one IDLE cycle per vector.
- in_vec and in_valid are ignored in EMIT.
- Lowest-set-bit selection and bit clearing are purely combinational on pending (pending & (pending-1) is acceptable). The index encode must be a single-cycle path at target frequency.

Test Plan:
- Reset, then in_vec=64'h1, out_ready=1 -> one beat: out_idx=0, out_last=1, out_none=0, out_beat=0; in_ready=1 two cycles after accept.
- in_vec=64'h8000_0020_0000_0001, out_ready=1 -> beats out_idx=0, 37, 63; out_beat=0, 1, 2; out_last high only on idx 63; in_ready low throughout.
- in_vec=all ones, out_ready=1 -> 64 consecutive beats, out_idx=out_beat=0..63, out_last only on beat 63; next vector accepted 65 cycles after the first accept.
- in_vec=64'h0 -> single beat: out_none=1, out_last=1, out_idx=0.
- in_vec=64'hF0, out_ready low 3 cycles on the first beat -> out_idx=4 and out_beat=0 held stable for 3 cycles; then idx 5, 6, 7 follow with no skipped or repeated index.
- in_vec=64'hFF00, reset_n pulsed low after beat idx 9 -> outputs go to reset values immediately; after release no further beats, in_ready=1; next vector 64'h2 yields a single beat idx 1.

Source files
------------

// File: rtl/onehot_scan_encoder.sv
// Sequential 64-to-6 encoder: accepts a request vector, then emits the index of
// every set bit in ascending order, one index per accepted output beat.
module onehot_scan_encoder #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none,
    output logic [W-1:0] out_beat,
    output logic         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and the beat on out_* is held
    // stable while out_valid && !out_ready.

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   beat_q, beat_d;
    logic           zero_q, zero_d;

    logic [W-1:0]   low_idx;
    logic [N-1:0]   pending_cleared;
    logic           at_most_one;

    // Descending scan so the lowest set bit is the last, winning assignment.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = W'(i);
            end
        end
    end

    assign pending_cleared = pending_q & (pending_q - N'(1));
    assign at_most_one     = (pending_cleared == '0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        beat_d    = beat_q;
        zero_d    = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pending_d = in_vec;
                    beat_d    = '0;
                    zero_d    = (in_vec == '0);
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_d = pending_cleared;
                    beat_d    = beat_q + W'(1);
                    if (at_most_one) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            beat_q    <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            beat_q    <= beat_d;
            zero_q    <= zero_d;
        end
    end

    // All outputs come from registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_idx   = low_idx;
    assign out_last  = (state_q == EMIT) && at_most_one;
    assign out_none  = (state_q == EMIT) && zero_q;
    assign out_beat  = beat_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Directed bench for onehot_scan_encoder: each task drives one scenario and
// checks outputs inline against hand-computed expectations.
module tb_onehot_scan_encoder;

    localparam int N = 64;
    localparam int W = 6;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_none;
    logic [W-1:0] out_beat;
    logic         dbg_state;

    int total;
    int bad;
    int cyc;
    int accept_cyc;

    onehot_scan_encoder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none),
        .out_beat  (out_beat),
        .dbg_state (dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: present a vector until accepted; returns just after the accept edge.
    task automatic send_vec(input logic [N-1:0] v);
        int waited;
        waited   = 0;
        in_vec   = v;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            step();
            waited++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        step();
        accept_cyc = cyc;
        in_valid   = 1'b0;
        in_vec     = '0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        step();
        step();
        total++;
        if ({out_valid, out_idx, out_last, out_none, out_beat, in_ready, dbg_state}
            !== {1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_values valid=%0b idx=%0d last=%0b none=%0b beat=%0d rdy=%0b required 0 0 0 0 0 1",
                     out_valid, out_idx, out_last, out_none, out_beat, in_ready);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        send_vec(64'h1);
        total++;
        if ({out_valid, out_idx, out_last, out_none, out_beat, in_ready}
            !== {1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0}) begin
            bad++;
            $display("FAIL single_beat valid=%0b idx=%0d last=%0b none=%0b beat=%0d rdy=%0b required 1 0 1 0 0 0",
                     out_valid, out_idx, out_last, out_none, out_beat, in_ready);
        end
        step();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL single_done valid=%0b rdy=%0b required valid=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_three_bits();
        logic [W-1:0] exp_idx [3];
        exp_idx[0] = 6'd0;
        exp_idx[1] = 6'd37;
        exp_idx[2] = 6'd63;
        send_vec(64'h8000_0020_0000_0001);
        for (int b = 0; b < 3; b++) begin
            total++;
            if ({out_valid, out_idx, out_beat, out_last, out_none, in_ready}
                !== {1'b1, exp_idx[b], 6'(b), (b == 2), 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL three_beat%0d valid=%0b idx=%0d beat=%0d last=%0b none=%0b rdy=%0b required idx=%0d beat=%0d last=%0b",
                         b, out_valid, out_idx, out_beat, out_last, out_none, in_ready, exp_idx[b], b, (b == 2));
            end
            step();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL three_done valid=%0b required=0", out_valid);
        end
    endtask

    task automatic test_all_ones_back_to_back();
        int first_cyc;
        send_vec({N{1'b1}});
        first_cyc = accept_cyc;
        for (int b = 0; b < 64; b++) begin
            total++;
            if ({out_valid, out_idx, out_beat, out_last, out_none}
                !== {1'b1, 6'(b), 6'(b), (b == 63), 1'b0}) begin
                bad++;
                $display("FAIL ones_beat%0d valid=%0b idx=%0d beat=%0d last=%0b none=%0b required idx=beat=%0d last=%0b",
                         b, out_valid, out_idx, out_beat, out_last, out_none, b, (b == 63));
            end
            step();
        end
        // Zero vector goes straight in behind it.
        send_vec(64'h0);
        total++;
        if (accept_cyc - first_cyc !== 65) begin
            bad++;
            $display("FAIL ones_throughput gap=%0d required=65", accept_cyc - first_cyc);
        end
        total++;
        if ({out_valid, out_idx, out_last, out_none, out_beat}
            !== {1'b1, 6'd0, 1'b1, 1'b1, 6'd0}) begin
            bad++;
            $display("FAIL zero_beat valid=%0b idx=%0d last=%0b none=%0b beat=%0d required 1 0 1 1 0",
                     out_valid, out_idx, out_last, out_none, out_beat);
        end
        step();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL zero_done valid=%0b rdy=%0b required valid=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send_vec(64'hF0);
        for (int s = 0; s < 3; s++) begin
            total++;
            if ({out_valid, out_idx, out_beat, out_last} !== {1'b1, 6'd4, 6'd0, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold%0d valid=%0b idx=%0d beat=%0d last=%0b required 1 4 0 0",
                         s, out_valid, out_idx, out_beat, out_last);
            end
            step();
        end
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            total++;
            if ({out_valid, out_idx, out_beat, out_last} !== {1'b1, 6'(4 + b), 6'(b), (b == 3)}) begin
                bad++;
                $display("FAIL stall_beat%0d valid=%0b idx=%0d beat=%0d last=%0b required idx=%0d beat=%0d",
                         b, out_valid, out_idx, out_beat, out_last, 4 + b, b);
            end
            step();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_done valid=%0b required=0", out_valid);
        end
    endtask

    task automatic test_reset_mid_vector();
        send_vec(64'hFF00);
        for (int b = 0; b < 2; b++) begin
            total++;
            if ({out_valid, out_idx, out_beat} !== {1'b1, 6'(8 + b), 6'(b)}) begin
                bad++;
                $display("FAIL midrst_beat%0d valid=%0b idx=%0d beat=%0d required idx=%0d beat=%0d",
                         b, out_valid, out_idx, out_beat, 8 + b, b);
            end
            step();
        end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_idx, out_last, out_none, out_beat, in_ready}
            !== {1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1}) begin
            bad++;
            $display("FAIL midrst_async valid=%0b idx=%0d last=%0b none=%0b beat=%0d rdy=%0b required 0 0 0 0 0 1",
                     out_valid, out_idx, out_last, out_none, out_beat, in_ready);
        end
        step();
        reset_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            total++;
            if ({out_valid, in_ready} !== 2'b01) begin
                bad++;
                $display("FAIL midrst_quiet%0d valid=%0b rdy=%0b required valid=0 rdy=1", s, out_valid, in_ready);
            end
        end
        send_vec(64'h2);
        total++;
        if ({out_valid, out_idx, out_beat, out_last, out_none} !== {1'b1, 6'd1, 6'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL midrst_next valid=%0b idx=%0d beat=%0d last=%0b none=%0b required 1 1 0 1 0",
                     out_valid, out_idx, out_beat, out_last, out_none);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_next_done valid=%0b required=0", out_valid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_three_bits();
        test_all_ones_back_to_back();
        test_stall();
        test_reset_mid_vector();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
